// File: rtl/uart_pkg.sv
// Shared types and widths for the UART TX scheduler.
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WRITE,
        S_WAIT_DONE,
        S_ACK
    } state_t;

    localparam int BYTE_W = 8;
    localparam int GID_W  = 3;
endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser followed by an edge register; rise pulses for one clk cycle.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX path among N_REQ byte producers.
// Holds UART_WRITE for WR_EDGES bit-clock rises, then waits for IRQ_Tx or a timeout.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WR_EDGES = 2,
    parameter int TIMEOUT  = 65535
) (
    input  logic                    clk_CPU,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    input  logic [8*N_REQ-1:0]      req_data,
    input  logic [N_REQ-1:0]        req_bits,
    input  logic [N_REQ-1:0]        req_parity,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic                    busy,
    output logic [GID_W-1:0]        grant_id,
    input  logic                    uart_clock,
    input  logic                    IRQ_Tx,
    output logic                    UART_WRITE,
    output logic [BYTE_W-1:0]       DATA_IN_Tx,
    output logic                    UART_BITS,
    output logic                    UART_PARITY
);
    localparam int IW = $clog2(N_REQ);
    localparam int EW = $clog2(WR_EDGES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [IW-1:0]       ptr, gid, pick;
    logic [BYTE_W-1:0]   hold_data;
    logic                hold_bits, hold_par;
    logic [EW-1:0]       edge_cnt;
    logic [TW-1:0]       to_cnt;
    logic                uck_rise, irq_rise, pick_vld;
    logic [2*N_REQ-1:0]  req_dbl;
    logic [N_REQ-1:0]    req_rot;
    logic [BYTE_W-1:0]   data_arr [N_REQ];

    uart_sync_edge u_uck (.clk(clk_CPU), .rst_n(RST), .din(uart_clock), .rise(uck_rise));
    uart_sync_edge u_irq (.clk(clk_CPU), .rst_n(RST), .din(IRQ_Tx),     .rise(irq_rise));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
        assign data_arr[gi] = req_data[8*gi +: 8];
    end

    // req_rot[k] is requester (ptr+1+k) mod N_REQ, so bit 0 has top priority.
    always_comb begin
        req_dbl  = {req, req};
        req_rot  = N_REQ'(req_dbl >> (int'(ptr) + 1));
        pick_vld = |req_rot;
        pick     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pick = IW'((int'(ptr) + 1 + k) % N_REQ);
        end
    end

    assign grant_id = GID_W'(gid);

    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gid         <= '0;
            hold_data   <= '0;
            hold_bits   <= 1'b0;
            hold_par    <= 1'b0;
            edge_cnt    <= '0;
            to_cnt      <= '0;
            ack         <= '0;
            err         <= '0;
            busy        <= 1'b0;
            UART_WRITE  <= 1'b0;
            DATA_IN_Tx  <= '0;
            UART_BITS   <= 1'b0;
            UART_PARITY <= 1'b0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_ARB;
                        busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (pick_vld) begin
                        gid       <= pick;
                        hold_data <= data_arr[pick];
                        hold_bits <= req_bits[pick];
                        hold_par  <= req_parity[pick];
                        state     <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    DATA_IN_Tx  <= hold_data;
                    UART_BITS   <= hold_bits;
                    UART_PARITY <= hold_par;
                    edge_cnt    <= '0;
                    UART_WRITE  <= 1'b1;
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    if (uck_rise) begin
                        if (edge_cnt >= EW'(WR_EDGES - 1)) begin
                            UART_WRITE <= 1'b0;
                            to_cnt     <= '0;
                            state      <= S_WAIT_DONE;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (irq_rise) begin
                        ack   <= N_REQ'(1) << gid;
                        state <= S_ACK;
                    end else if (to_cnt >= TW'(TIMEOUT - 1)) begin
                        // Aborted requester still moves to lowest priority.
                        err   <= N_REQ'(1) << gid;
                        ptr   <= gid;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    ptr   <= gid;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    UART_WRITE <= 1'b0;
                end
            endcase
        end
    end
endmodule
